// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//   Memory-access stage of the 5-stage MIPS pipeline. Contains the EX/MEM
//   pipeline register, a word-addressed data memory, the MEM/WB pipeline
//   register and the write-back mux. A small IDLE/WAIT controller models a
//   multi-cycle data memory: while a load/store is still in flight it raises
//   mem_stall, which freezes the upstream stages and EX/MEM and pushes
//   bubbles into MEM/WB.
//
// Parameters
//   DEPTH        data-memory size in 32-bit words (power of 2)
//   MEM_LATENCY  cycles a load/store occupies EX/MEM (>=1, 1 = never stalls)
//
// Ports
//   clock, reset         rising-edge clock, synchronous active-high reset
//   EXMWB[1:0]           WB control from EX: [0]=RegWrite, [1]=MemtoReg
//   EXMM[2:0]            MEM control from EX: [0]=MemWrite, [1]=MemRead,
//                        [2]=reserved (registered, unused)
//   EXALUOut[31:0]       ALU result / byte address
//   EXMWriteDataIn[31:0] store data
//   regtopass[4:0]       destination register
//   EXMEMRegRd, EXMEM_RegWrite, MEMALUOut   EX/MEM forwarding taps
//   MEMWBRegRd, MEMWB_RegWrite, datatowrite MEM/WB write-back / forwarding
//   mem_stall            hold IF/ID/EX and EX/MEM this cycle
// -----------------------------------------------------------------------------
module mem_stage #(
  parameter int DEPTH       = 256,
  parameter int MEM_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  EXMWB,
  input  logic [2:0]  EXMM,
  input  logic [31:0] EXALUOut,
  input  logic [31:0] EXMWriteDataIn,
  input  logic [4:0]  regtopass,
  output logic [4:0]  EXMEMRegRd,
  output logic [1:0]  EXMEM_RegWrite,
  output logic [31:0] MEMALUOut,
  output logic [4:0]  MEMWBRegRd,
  output logic [1:0]  MEMWB_RegWrite,
  output logic [31:0] datatowrite,
  output logic        mem_stall
);

  localparam int AW = $clog2(DEPTH);
  // Counter only needs to reach MEM_LATENCY-1; keep at least one bit.
  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LATENCY - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // EX/MEM register
  logic [1:0]  exmem_wb_reg;
  logic [2:0]  exmem_m_reg;
  logic [31:0] exmem_alu_reg;
  logic [31:0] exmem_wdata_reg;
  logic [4:0]  exmem_rd_reg;

  // MEM/WB register
  logic [1:0]  memwb_wb_reg;
  logic [4:0]  memwb_rd_reg;
  logic [31:0] memwb_alu_reg;
  logic [31:0] memwb_rdata_reg;

  // Latency controller
  state_t      state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;

  // Data memory
  logic [31:0] mem_array [DEPTH];
  logic [AW-1:0] word_addr;
  logic [31:0] rdata;
  logic        memop;
  logic        mem_we;
  logic        reserved_unused;

  assign memop     = exmem_m_reg[0] | exmem_m_reg[1];
  // Upper address bits are dropped, so addresses alias modulo DEPTH words.
  assign word_addr = exmem_alu_reg[AW+1:2];
  assign mem_stall = memop && (cnt_reg != CNT_LAST);
  // Write only on the completing cycle so a store lands exactly once.
  assign mem_we    = exmem_m_reg[0] && !mem_stall;
  assign rdata     = mem_array[word_addr];
  assign reserved_unused = exmem_m_reg[2];

  // ---------------------------------------------------------------------------
  // Latency controller
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (mem_stall) begin
          state_next = ST_WAIT;
          cnt_next   = CW'(1);
        end else begin
          cnt_next   = '0;
        end
      end
      ST_WAIT: begin
        if (mem_stall) begin
          cnt_next   = cnt_reg + 1'b1;
        end else begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // EX/MEM register: frozen while the memory is busy
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      exmem_wb_reg    <= '0;
      exmem_m_reg     <= '0;
      exmem_alu_reg   <= '0;
      exmem_wdata_reg <= '0;
      exmem_rd_reg    <= '0;
    end else if (!mem_stall) begin
      exmem_wb_reg    <= EXMWB;
      exmem_m_reg     <= EXMM;
      exmem_alu_reg   <= EXALUOut;
      exmem_wdata_reg <= EXMWriteDataIn;
      exmem_rd_reg    <= regtopass;
    end
  end

  // ---------------------------------------------------------------------------
  // Data memory write port. Not reset-cleared; reset only blocks a write that
  // would otherwise land on the same edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset && mem_we) begin
      mem_array[word_addr] <= exmem_wdata_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // MEM/WB register: bubble while the memory is busy. The read data is the
  // pre-write contents when a single op both reads and writes.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      memwb_wb_reg    <= '0;
      memwb_rd_reg    <= '0;
      memwb_alu_reg   <= '0;
      memwb_rdata_reg <= '0;
    end else if (mem_stall) begin
      memwb_wb_reg    <= '0;
      memwb_rd_reg    <= '0;
      memwb_alu_reg   <= '0;
      memwb_rdata_reg <= '0;
    end else begin
      memwb_wb_reg    <= exmem_wb_reg;
      memwb_rd_reg    <= exmem_rd_reg;
      memwb_alu_reg   <= exmem_alu_reg;
      memwb_rdata_reg <= rdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign EXMEMRegRd     = exmem_rd_reg;
  assign EXMEM_RegWrite = exmem_wb_reg;
  assign MEMALUOut      = exmem_alu_reg;
  assign MEMWBRegRd     = memwb_rd_reg;
  assign MEMWB_RegWrite = memwb_wb_reg;
  assign datatowrite    = memwb_wb_reg[1] ? memwb_rdata_reg : memwb_alu_reg;

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
//   Two instances of mem_stage: one with single-cycle memory, one with a
//   three-cycle memory. A select bit routes the bench's EX-side stimulus to
//   one instance while the other sees NOPs. Directed scenarios check timing;
//   a random stream is checked against an in-order program-semantics model.
// -----------------------------------------------------------------------------
module tb_mem_stage;

  localparam int DEPTH = 256;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        sel;
  logic [1:0]  in_wb;
  logic [2:0]  in_m;
  logic [31:0] in_alu;
  logic [31:0] in_wd;
  logic [4:0]  in_rd;

  // Per-instance inputs
  logic [1:0]  d0_wb, d1_wb;
  logic [2:0]  d0_m, d1_m;
  logic [31:0] d0_alu, d1_alu, d0_wd, d1_wd;
  logic [4:0]  d0_rd, d1_rd;

  assign d0_wb  = sel ? 2'b00 : in_wb;
  assign d0_m   = sel ? 3'b000 : in_m;
  assign d0_alu = sel ? 32'h0 : in_alu;
  assign d0_wd  = sel ? 32'h0 : in_wd;
  assign d0_rd  = sel ? 5'd0 : in_rd;
  assign d1_wb  = sel ? in_wb : 2'b00;
  assign d1_m   = sel ? in_m : 3'b000;
  assign d1_alu = sel ? in_alu : 32'h0;
  assign d1_wd  = sel ? in_wd : 32'h0;
  assign d1_rd  = sel ? in_rd : 5'd0;

  // Per-instance outputs
  logic [4:0]  a_exrd, b_exrd, a_mwrd, b_mwrd;
  logic [1:0]  a_exrw, b_exrw, a_mwrw, b_mwrw;
  logic [31:0] a_malu, b_malu, a_dtw, b_dtw;
  logic        a_stall, b_stall;

  mem_stage #(.DEPTH(DEPTH), .MEM_LATENCY(1)) u_lat1 (
    .clock(clock), .reset(reset),
    .EXMWB(d0_wb), .EXMM(d0_m), .EXALUOut(d0_alu), .EXMWriteDataIn(d0_wd),
    .regtopass(d0_rd),
    .EXMEMRegRd(a_exrd), .EXMEM_RegWrite(a_exrw), .MEMALUOut(a_malu),
    .MEMWBRegRd(a_mwrd), .MEMWB_RegWrite(a_mwrw), .datatowrite(a_dtw),
    .mem_stall(a_stall)
  );

  mem_stage #(.DEPTH(DEPTH), .MEM_LATENCY(3)) u_lat3 (
    .clock(clock), .reset(reset),
    .EXMWB(d1_wb), .EXMM(d1_m), .EXALUOut(d1_alu), .EXMWriteDataIn(d1_wd),
    .regtopass(d1_rd),
    .EXMEMRegRd(b_exrd), .EXMEM_RegWrite(b_exrw), .MEMALUOut(b_malu),
    .MEMWBRegRd(b_mwrd), .MEMWB_RegWrite(b_mwrw), .datatowrite(b_dtw),
    .mem_stall(b_stall)
  );

  // Outputs of the selected instance
  logic [4:0]  o_exrd, o_mwrd;
  logic [1:0]  o_exrw, o_mwrw;
  logic [31:0] o_malu, o_dtw;
  logic        o_stall;
  assign o_exrd  = sel ? b_exrd  : a_exrd;
  assign o_exrw  = sel ? b_exrw  : a_exrw;
  assign o_malu  = sel ? b_malu  : a_malu;
  assign o_mwrd  = sel ? b_mwrd  : a_mwrd;
  assign o_mwrw  = sel ? b_mwrw  : a_mwrw;
  assign o_dtw   = sel ? b_dtw   : a_dtw;
  assign o_stall = sel ? b_stall : a_stall;

  logic [78:0] a_all, b_all;
  assign a_all = {a_exrd, a_exrw, a_malu, a_mwrd, a_mwrw, a_dtw, a_stall};
  assign b_all = {b_exrd, b_exrw, b_malu, b_mwrd, b_mwrw, b_dtw, b_stall};

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: memory contents in program order, expected retirements
  typedef struct packed {
    logic [1:0]  wb;
    logic [4:0]  rd;
    logic [31:0] data;
  } rec_t;
  logic [31:0] model_mem [2][DEPTH];
  rec_t        exp_q[$];

  task automatic drive(input logic [1:0] wb, input logic [2:0] m,
                       input logic [31:0] alu, input logic [31:0] wd,
                       input logic [4:0] rd);
    in_wb  = wb;
    in_m   = m;
    in_alu = alu;
    in_wd  = wd;
    in_rd  = rd;
  endtask

  task automatic nop();
    drive(2'b00, 3'b000, 32'h0, 32'h0, 5'd0);
  endtask

  // Advance one cycle; returns at the falling edge, where outputs are sampled.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset_state();
    reset = 1'b1;
    sel   = 1'b0;
    nop();
    step();
    step();
    n_checks++;
    if (a_all !== 79'd0 || b_all !== 79'd0)
      $display("FAIL reset_state: lat1=%h lat3=%h, want all zero", a_all, b_all);
    if (a_all !== 79'd0 || b_all !== 79'd0) n_fail++;
    reset = 1'b0;
    step();
  endtask

  task automatic test_alu_op();
    sel = 1'b0;
    drive(2'b01, 3'b000, 32'h1234, 32'h0, 5'd5);
    step();
    nop();
    n_checks++;
    if ({o_exrd, o_exrw, o_malu} !== {5'd5, 2'b01, 32'h1234}) begin
      n_fail++;
      $display("FAIL alu_exmem: rd=%0d rw=%b alu=%h, want rd=5 rw=01 alu=1234",
               o_exrd, o_exrw, o_malu);
    end
    n_checks++;
    if (o_mwrw !== 2'b00) begin
      n_fail++;
      $display("FAIL alu_early: MEM/WB rw=%b one edge after EX/MEM load, want 00", o_mwrw);
    end
    step();
    n_checks++;
    if ({o_mwrd, o_mwrw, o_dtw} !== {5'd5, 2'b01, 32'h1234}) begin
      n_fail++;
      $display("FAIL alu_memwb: rd=%0d rw=%b data=%h, want rd=5 rw=01 data=1234",
               o_mwrd, o_mwrw, o_dtw);
    end
  endtask

  task automatic test_store_load();
    sel = 1'b0;
    drive(2'b00, 3'b001, 32'h10, 32'hDEADBEEF, 5'd0);
    step();
    drive(2'b11, 3'b010, 32'h10, 32'h0, 5'd8);
    step();
    nop();
    n_checks++;
    if (o_mwrw !== 2'b00) begin
      n_fail++;
      $display("FAIL store_memwb: rw=%b, want 00", o_mwrw);
    end
    step();
    n_checks++;
    if ({o_mwrd, o_mwrw, o_dtw} !== {5'd8, 2'b11, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL store_then_load: rd=%0d rw=%b data=%h, want rd=8 rw=11 data=deadbeef",
               o_mwrd, o_mwrw, o_dtw);
    end
  endtask

  task automatic test_alias();
    sel = 1'b0;
    drive(2'b00, 3'b001, 32'h400, 32'hA5, 5'd0);
    step();
    drive(2'b11, 3'b010, 32'h000, 32'h0, 5'd4);
    step();
    nop();
    step();
    n_checks++;
    if ({o_mwrd, o_dtw} !== {5'd4, 32'hA5}) begin
      n_fail++;
      $display("FAIL alias: rd=%0d data=%h, want rd=4 data=a5", o_mwrd, o_dtw);
    end
  endtask

  task automatic test_stall();
    sel = 1'b1;
    nop();
    step();
    step();
    // Store, with an ALU op queued behind it that must be held
    drive(2'b00, 3'b001, 32'h10, 32'hCAFE0010, 5'd0);
    step();
    drive(2'b01, 3'b000, 32'h77, 32'h0, 5'd3);
    n_checks++;
    if (o_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_c0: stall=%b, want 1", o_stall);
    end
    step();
    n_checks++;
    if ({o_stall, o_malu, o_mwrw} !== {1'b1, 32'h10, 2'b00}) begin
      n_fail++;
      $display("FAIL stall_c1: stall=%b alu=%h mwrw=%b, want 1 10 00", o_stall, o_malu, o_mwrw);
    end
    step();
    n_checks++;
    if ({o_stall, o_malu} !== {1'b0, 32'h10}) begin
      n_fail++;
      $display("FAIL stall_c2: stall=%b alu=%h, want 0 10", o_stall, o_malu);
    end
    step();
    nop();
    n_checks++;
    if ({o_stall, o_exrd, o_malu} !== {1'b0, 5'd3, 32'h77}) begin
      n_fail++;
      $display("FAIL held_op_enter: stall=%b rd=%0d alu=%h, want 0 3 77", o_stall, o_exrd, o_malu);
    end
    step();
    n_checks++;
    if ({o_mwrd, o_mwrw, o_dtw} !== {5'd3, 2'b01, 32'h77}) begin
      n_fail++;
      $display("FAIL held_op_wb: rd=%0d rw=%b data=%h, want 3 01 77", o_mwrd, o_mwrw, o_dtw);
    end
    // Load of the same address
    drive(2'b11, 3'b010, 32'h10, 32'h0, 5'd8);
    step();
    nop();
    n_checks++;
    if (o_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL load_stall_c0: stall=%b, want 1", o_stall);
    end
    step();
    n_checks++;
    if ({o_stall, o_mwrw} !== {1'b1, 2'b00}) begin
      n_fail++;
      $display("FAIL load_stall_c1: stall=%b mwrw=%b, want 1 00", o_stall, o_mwrw);
    end
    step();
    n_checks++;
    if ({o_stall, o_mwrw} !== {1'b0, 2'b00}) begin
      n_fail++;
      $display("FAIL load_stall_c2: stall=%b mwrw=%b, want 0 00", o_stall, o_mwrw);
    end
    step();
    n_checks++;
    if ({o_mwrd, o_mwrw, o_dtw} !== {5'd8, 2'b11, 32'hCAFE0010}) begin
      n_fail++;
      $display("FAIL load_lat3: rd=%0d rw=%b data=%h, want 8 11 cafe0010", o_mwrd, o_mwrw, o_dtw);
    end
  endtask

  task automatic test_reset_in_wait();
    sel = 1'b1;
    drive(2'b00, 3'b001, 32'h20, 32'h11111111, 5'd0);
    step();
    nop();
    step();
    step();
    step();
    drive(2'b00, 3'b001, 32'h20, 32'h55, 5'd0);
    step();
    nop();
    step();
    step();
    // Now on the store's completing cycle; reset must still drop it
    n_checks++;
    if (o_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_complete: stall=%b, want 0", o_stall);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++;
    if (b_all !== 79'd0) begin
      n_fail++;
      $display("FAIL reset_wait_clear: outputs=%h, want zero", b_all);
    end
    drive(2'b11, 3'b010, 32'h20, 32'h0, 5'd7);
    step();
    nop();
    step();
    step();
    step();
    n_checks++;
    if ({o_mwrd, o_dtw} !== {5'd7, 32'h11111111}) begin
      n_fail++;
      $display("FAIL reset_drops_store: rd=%0d data=%h, want 7 11111111", o_mwrd, o_dtw);
    end
  endtask

  task automatic test_reset_mid_traffic();
    sel = 1'b1;
    drive(2'b11, 3'b010, 32'h40, 32'h0, 5'd9);
    step();
    drive(2'b01, 3'b000, 32'h99, 32'h0, 5'd2);
    reset = 1'b1;
    step();
    step();
    n_checks++;
    if (a_all !== 79'd0 || b_all !== 79'd0) begin
      n_fail++;
      $display("FAIL reset_mid: lat1=%h lat3=%h, want zero", a_all, b_all);
    end
    reset = 1'b0;
    nop();
    step();
    n_checks++;
    if (b_stall !== 1'b0 || b_all !== 79'd0) begin
      n_fail++;
      $display("FAIL reset_after: stall=%b outputs=%h, want 0 and zero", b_stall, b_all);
    end
  endtask

  // Random back-to-back stream; first 8 ops initialise word indices 0..7
  task automatic test_back_to_back(input logic which, input int n_ops);
    int          issued;
    logic        have;
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [31:0] alu, wd, old;
    logic [4:0]  rd;
    logic [7:0]  widx;
    rec_t        e;
    sel = which;
    nop();
    step();
    step();
    exp_q.delete();
    issued = 0;
    have   = 1'b0;
    wb = '0; m = '0; alu = '0; wd = '0; rd = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      n_checks++;
      if (o_mwrw != 2'b00) begin
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rnd_extra: unexpected retire rd=%0d rw=%b data=%h", o_mwrd, o_mwrw, o_dtw);
        end else begin
          e = exp_q.pop_front();
          if ({o_mwrw, o_mwrd, o_dtw} !== {e.wb, e.rd, e.data}) begin
            n_fail++;
            $display("FAIL rnd_retire: rw=%b rd=%0d data=%h, want rw=%b rd=%0d data=%h",
                     o_mwrw, o_mwrd, o_dtw, e.wb, e.rd, e.data);
          end
        end
      end else if ({o_mwrd, o_dtw} !== 37'd0) begin
        n_fail++;
        $display("FAIL rnd_bubble: rd=%0d data=%h, want 0 0", o_mwrd, o_dtw);
      end
      if (issued == n_ops && exp_q.size() == 0) break;
      if (issued < n_ops) begin
        if (!have) begin
          rd = 5'($urandom_range(0, 31));
          wd = $urandom();
          if (issued < 8) begin
            wb  = 2'b01;
            m   = 3'b001;
            alu = 32'(issued) << 2;
          end else begin
            wb  = 2'($urandom_range(1, 3));
            m   = 3'($urandom_range(0, 7));
            alu = ($urandom() & 32'hFFFF_FC03) | (32'($urandom_range(0, 7)) << 2);
          end
        end
        drive(wb, m, alu, wd, rd);
        if (!o_stall) begin
          widx   = alu[9:2];
          old    = model_mem[which][widx];
          e.wb   = wb;
          e.rd   = rd;
          e.data = wb[1] ? old : alu;
          if (m[0]) model_mem[which][widx] = wd;
          exp_q.push_back(e);
          issued++;
          have = 1'b0;
        end else begin
          have = 1'b1;
        end
      end else begin
        nop();
      end
      step();
    end
    n_checks++;
    if (issued != n_ops || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rnd_timeout: issued=%0d of %0d, pending=%0d", issued, n_ops, exp_q.size());
    end
    nop();
  endtask

  initial begin
    reset = 1'b1;
    sel   = 1'b0;
    nop();
    @(negedge clock);
    test_reset_state();
    test_alu_op();
    test_store_load();
    test_alias();
    test_stall();
    test_reset_in_wait();
    test_reset_mid_traffic();
    test_back_to_back(1'b0, 80);
    test_back_to_back(1'b1, 80);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
